// File: rtl/clock_set_ctrl.sv
// ---------------------------------------------------------------------------
// clock_set_ctrl
//   Mode/time-set controller for the 24-hour clock datapath. Decodes the
//   mode/inc/dec push-buttons and drives single-cycle enable pulses into the
//   external seconds/minutes/hours counters. Holds no time value itself.
//   Also provides the display blink phase, hold-to-repeat and an idle
//   timeout that returns to RUN.
//
// Parameters
//   REPEAT_DELAY : sec_tick pulses a button is held before auto-repeat (>=1)
//   IDLE_TIMEOUT : sec_tick pulses without a button rise in a SET mode
//                  before forced return to RUN (>=1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   sec_tick in   one-clk-wide 1 Hz enable
//   mode_btn in   mode button level (synchronised, debounced)
//   inc_btn  in   increment button level
//   dec_btn  in   decrement button level
//   mode     out  00 RUN, 01 SET_HR, 10 SET_MIN
//   count_en out  seconds advance enable (combinational, RUN only)
//   sec_clr  out  seconds clear pulse on SET_MIN -> RUN
//   hr_inc / hr_dec / min_inc / min_dec  out  one-cycle adjust pulses
//   blink    out  display blink phase for the field being set
//
// Build option
//   CLOCK_SET_DEC_EN : when defined, dec_btn is functional. When undefined,
//   dec_btn is ignored and hr_dec/min_dec are tied low.
//
// state      | meaning
// -----------+----------------------------------------------
// ST_RUN     | time runs, inc/dec ignored, blink off
// ST_SET_HR  | seconds frozen, inc/dec adjust hours
// ST_SET_MIN | seconds frozen, inc/dec adjust minutes
// ---------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter int unsigned REPEAT_DELAY = 2,
    parameter int unsigned IDLE_TIMEOUT = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       dec_btn,
    output logic [1:0] mode,
    output logic       count_en,
    output logic       sec_clr,
    output logic       hr_inc,
    output logic       hr_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic       blink
);

    localparam int unsigned RW = $clog2(REPEAT_DELAY) + 1;
    localparam int unsigned IW = $clog2(IDLE_TIMEOUT) + 1;
    localparam logic [RW-1:0] REP_MAX   = RW'(REPEAT_DELAY);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] hold_cnt_q, hold_cnt_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic          sec_clr_q, sec_clr_d;
    logic          hr_inc_q, hr_inc_d;
    logic          hr_dec_q, hr_dec_d;
    logic          min_inc_q, min_inc_d;
    logic          min_dec_q, min_dec_d;

    logic rise_mode, rise_inc, rise_dec;
    logic inc_act, dec_act;     // single-press adjust requests
    logic inc_hold, dec_hold;   // exactly one adjust button held
    logic any_rise;

`ifdef CLOCK_SET_DEC_EN
    logic [2:0] btn_hist_q, btn_hist_d;
    assign btn_hist_d = {dec_btn, inc_btn, mode_btn};
    assign rise_mode  = mode_btn & ~btn_hist_q[0];
    assign rise_inc   = inc_btn & ~btn_hist_q[1];
    assign rise_dec   = dec_btn & ~btn_hist_q[2];
    // Simultaneous inc+dec rises cancel each other.
    assign inc_act    = rise_inc & ~rise_dec;
    assign dec_act    = rise_dec & ~rise_inc;
    assign inc_hold   = inc_btn & ~dec_btn;
    assign dec_hold   = dec_btn & ~inc_btn;
`else
    logic [1:0] btn_hist_q, btn_hist_d;
    logic       unused_dec;
    assign unused_dec = dec_btn;
    assign btn_hist_d = {inc_btn, mode_btn};
    assign rise_mode  = mode_btn & ~btn_hist_q[0];
    assign rise_inc   = inc_btn & ~btn_hist_q[1];
    assign rise_dec   = 1'b0;
    assign inc_act    = rise_inc;
    assign dec_act    = 1'b0;
    assign inc_hold   = inc_btn;
    assign dec_hold   = 1'b0;
`endif

    assign any_rise = rise_mode | rise_inc | rise_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            btn_hist_q <= '0;
            hold_cnt_q <= '0;
            idle_cnt_q <= '0;
            blink_ph_q <= 1'b0;
            sec_clr_q  <= 1'b0;
            hr_inc_q   <= 1'b0;
            hr_dec_q   <= 1'b0;
            min_inc_q  <= 1'b0;
            min_dec_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_hist_q <= btn_hist_d;
            hold_cnt_q <= hold_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            blink_ph_q <= blink_ph_d;
            sec_clr_q  <= sec_clr_d;
            hr_inc_q   <= hr_inc_d;
            hr_dec_q   <= hr_dec_d;
            min_inc_q  <= min_inc_d;
            min_dec_q  <= min_dec_d;
        end
    end

    logic set_mode;
    logic rep_fire;
    logic timeout;
    logic adj_inc, adj_dec;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        idle_cnt_d = idle_cnt_q;
        blink_ph_d = blink_ph_q;
        sec_clr_d  = 1'b0;
        hr_inc_d   = 1'b0;
        hr_dec_d   = 1'b0;
        min_inc_d  = 1'b0;
        min_dec_d  = 1'b0;
        rep_fire   = 1'b0;

        set_mode = (state_q != ST_RUN);

        // Hold counter saturates at REPEAT_DELAY; from then on every tick fires.
        if (set_mode && (inc_hold || dec_hold)) begin
            if (sec_tick) begin
                if (hold_cnt_q >= REP_MAX) begin
                    rep_fire = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + RW'(1);
                end
            end
        end else begin
            hold_cnt_d = '0;
        end

        // Any button rise restarts the idle count, so it also wins over timeout.
        timeout = set_mode && !any_rise && sec_tick && (idle_cnt_q >= IDLE_LAST);

        adj_inc = set_mode && !rise_mode && !timeout && (inc_act || (rep_fire && inc_hold));
        adj_dec = set_mode && !rise_mode && !timeout && (dec_act || (rep_fire && dec_hold));

        if (rise_mode) begin
            hold_cnt_d = '0;
            idle_cnt_d = '0;
            unique case (state_q)
                ST_RUN: begin
                    state_d    = ST_SET_HR;
                    blink_ph_d = 1'b1;
                end
                ST_SET_HR: begin
                    state_d    = ST_SET_MIN;
                    blink_ph_d = 1'b1;
                end
                default: begin
                    state_d    = ST_RUN;
                    sec_clr_d  = 1'b1;
                    blink_ph_d = 1'b0;
                end
            endcase
        end else if (timeout) begin
            state_d    = ST_RUN;
            hold_cnt_d = '0;
            idle_cnt_d = '0;
            blink_ph_d = 1'b0;
        end else if (set_mode) begin
            if (sec_tick) begin
                blink_ph_d = ~blink_ph_q;
            end
            if (any_rise) begin
                idle_cnt_d = '0;
            end else if (sec_tick) begin
                idle_cnt_d = idle_cnt_q + IW'(1);
            end
            if (state_q == ST_SET_HR) begin
                hr_inc_d = adj_inc;
                hr_dec_d = adj_dec;
            end else begin
                min_inc_d = adj_inc;
                min_dec_d = adj_dec;
            end
        end else begin
            idle_cnt_d = '0;
            blink_ph_d = 1'b0;
        end
    end

    assign mode     = state_q;
    assign count_en = sec_tick & (state_q == ST_RUN);
    assign sec_clr  = sec_clr_q;
    assign hr_inc   = hr_inc_q;
    assign hr_dec   = hr_dec_q;
    assign min_inc  = min_inc_q;
    assign min_dec  = min_dec_q;
    // Keep the edited field visible in the cycle it changes.
    assign blink    = blink_ph_q | hr_inc_q | hr_dec_q | min_inc_q | min_dec_q;

endmodule
